// File: rtl/frog_sprite_reader_if.sv
// Video-side bundle for the frog sprite reader: timing/position inputs,
// the font ROM address/data pair and the sprite pixel outputs.
interface frog_sprite_reader_if;
    logic        line_start;
    logic        pixel_en;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [9:0]  FrogX;
    logic [9:0]  FrogY;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sprite_on;
    logic        busy;

    modport master (
        output line_start, pixel_en, DrawX, DrawY, FrogX, FrogY, rom_data,
        input  rom_addr, sprite_on, busy
    );

    modport slave (
        input  line_start, pixel_en, DrawX, DrawY, FrogX, FrogY, rom_data,
        output rom_addr, sprite_on, busy
    );
endinterface

// File: rtl/frog_sprite_reader.sv
// Per-scanline frog sprite reader: fetches one 16-pixel ROM row at line_start
// and shifts it out MSB-first starting at the latched sprite column.
module frog_sprite_reader #(
    parameter logic [4:0] SPRITE_BASE = 5'd16,
    parameter int         SPRITE_H    = 16
) (
    input logic                  Clk,
    input logic                  Reset_n,
    frog_sprite_reader_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_ARMED = 3'd3,
        ST_SHIFT = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [4:0]         r_rom_addr;
    logic [15:0]        r_shreg;
    logic [4:0]         r_cnt;
    logic [9:0]         r_x_lat;
    logic [4:0]         r_row;
    logic               r_sprite_on;

    logic signed [10:0] w_row;
    logic               w_in_range;
    logic               w_match;
    logic               w_cnt_done;

    logic               w_capture;
    logic               w_clear_shreg;
    logic               w_load_addr;
    logic               w_load_shreg;
    logic               w_first;
    logic               w_shift;
    logic               w_end;
    logic               w_busy;

    // Row within the sprite; the extra sign bit makes lines above the sprite negative.
    assign w_row      = $signed({1'b0, bus.DrawY}) - $signed({1'b0, bus.FrogY});
    assign w_in_range = (w_row[10] == 1'b0) && (w_row[9:0] < 10'(SPRITE_H));
    assign w_match    = bus.pixel_en && (bus.DrawX == r_x_lat);
    assign w_cnt_done = (r_cnt == 5'd16);

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; line_start overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.line_start) begin
            if (w_in_range) begin
                w_state_nxt = ST_FETCH;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_IDLE;
                ST_FETCH: w_state_nxt = ST_LATCH;
                ST_LATCH: w_state_nxt = ST_ARMED;
                ST_ARMED: begin
                    if (w_match) begin
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_state_nxt = ST_ARMED;
                    end
                end
                ST_SHIFT: begin
                    if (bus.pixel_en && w_cnt_done) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output/control decode: datapath strobes for the current state and inputs.
    always_comb begin
        w_capture     = bus.line_start;
        w_clear_shreg = bus.line_start && !w_in_range;
        w_load_addr   = 1'b0;
        w_load_shreg  = 1'b0;
        w_first       = 1'b0;
        w_shift       = 1'b0;
        w_end         = 1'b0;
        w_busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
            end
            ST_FETCH: begin
                w_busy      = 1'b1;
                w_load_addr = !bus.line_start;
            end
            ST_LATCH: begin
                w_busy       = 1'b1;
                w_load_shreg = !bus.line_start;
            end
            ST_ARMED: begin
                w_first = w_match && !bus.line_start;
                w_shift = w_match && !bus.line_start;
            end
            ST_SHIFT: begin
                w_shift = bus.pixel_en && !w_cnt_done && !bus.line_start;
                w_end   = bus.pixel_en && w_cnt_done && !bus.line_start;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Datapath registers: line context, ROM address, shifter, pixel counter, pixel output.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rom_addr  <= 5'd0;
            r_shreg     <= 16'd0;
            r_cnt       <= 5'd0;
            r_x_lat     <= 10'd0;
            r_row       <= 5'd0;
            r_sprite_on <= 1'b0;
        end else begin
            if (w_capture) begin
                r_x_lat <= bus.FrogX;
                r_row   <= w_row[4:0];
            end else begin
                r_x_lat <= r_x_lat;
                r_row   <= r_row;
            end

            if (w_load_addr) begin
                r_rom_addr <= SPRITE_BASE + r_row;
            end else begin
                r_rom_addr <= r_rom_addr;
            end

            if (w_clear_shreg) begin
                r_shreg <= 16'd0;
            end else if (w_load_shreg) begin
                r_shreg <= bus.rom_data;
            end else if (w_shift) begin
                r_shreg <= {r_shreg[14:0], 1'b0};
            end else begin
                r_shreg <= r_shreg;
            end

            if (w_first) begin
                r_cnt <= 5'd1;
            end else if (w_shift) begin
                r_cnt <= r_cnt + 5'd1;
            end else begin
                r_cnt <= r_cnt;
            end

            if (bus.line_start || w_end) begin
                r_sprite_on <= 1'b0;
            end else if (w_shift) begin
                r_sprite_on <= r_shreg[15];
            end else begin
                r_sprite_on <= r_sprite_on;
            end
        end
    end

    assign bus.rom_addr  = r_rom_addr;
    assign bus.sprite_on = r_sprite_on;
    assign bus.busy      = w_busy;

endmodule
